// File: rtl/muxn_stream_pkg.sv
// Shared definitions for the muxn_stream block: mode encodings and the width helper.
package mux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Minimum of 1 bit so that the select/grant fields never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/muxn_stream_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, with wrap.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int SEL_W   = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                grant_valid,
  output logic [SEL_W-1:0]    grant_id
);

  int idx;

  // Walk from the farthest offset down so that the nearest requester after ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = (int'(ptr) + i) % CHANNELS;
      if (req[SEL_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_id    = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// N-channel registered stream multiplexer with valid/ready handshake.
// Define MUXN_STREAM_RR_EN to compile in the round-robin arbiter and honour the mode input.
module muxn_stream
  import mux_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          grant_id
);

  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

  logic             load;
  logic             rr_mode;
  logic             cand_valid;
  logic [SEL_W-1:0] cand;
  logic             xfer;
  logic [WIDTH-1:0] cand_data;

`ifdef MUXN_STREAM_RR_EN
  logic [SEL_W-1:0] ptr;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_id;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .grant_valid (rr_valid),
    .grant_id    (rr_id)
  );

  assign rr_mode = (mode == MODE_RR);

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= SEL_W'(CHANNELS - 1);
    else if (xfer && rr_mode)
      ptr <= cand;
  end
`else
  logic unused_mode;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_id;

  assign unused_mode = mode;
  assign rr_mode     = MODE_SELECT;
  assign rr_valid    = 1'b0;
  assign rr_id       = '0;
`endif

  assign load = !out_valid || out_ready;

  always_comb begin
    cand       = sel;
    cand_valid = ({1'b0, sel} < CH_LIMIT);
    if (rr_mode) begin
      cand       = rr_id;
      cand_valid = rr_valid;
    end
  end

  // in_ready does not look at in_valid in SELECT mode; the producer sees ready regardless.
  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cand == SEL_W'(k)) begin
        in_ready[k] = load && cand_valid;
        cand_data   = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        grant_id  <= cand;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muxn_stream.sv
// Directed bench for muxn_stream: a 4-channel instance plus a 3-channel one for out-of-range select.
module tb_muxn_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] a_in_data = '0;
  logic [3:0]  a_in_valid = '0;
  logic [3:0]  a_in_ready;
  logic [1:0]  a_sel = '0;
  logic        a_mode = 1'b0;
  logic [4:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [1:0]  a_grant_id;

  logic [14:0] b_in_data = '0;
  logic [2:0]  b_in_valid = '0;
  logic [2:0]  b_in_ready;
  logic [1:0]  b_sel = '0;
  logic        b_mode = 1'b0;
  logic [4:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [1:0]  b_grant_id;

  int n_chk = 0;
  int n_pass = 0;

  muxn_stream #(.WIDTH(5), .CHANNELS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .grant_id(a_grant_id)
  );

  muxn_stream #(.WIDTH(5), .CHANNELS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .grant_id(b_grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_a(input int k, input logic [4:0] v);
    a_in_data[k*5 +: 5] = v;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [4:0] d, input logic [1:0] g);
    check({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    check({tag, ".data"},  32'(a_out_data),  32'(d));
    check({tag, ".grant"}, 32'(a_grant_id),  32'(g));
  endtask

`ifdef MUXN_STREAM_RR_EN
  task automatic rr_step(input string tag, input logic [1:0] g);
    tick();
    check_out(tag, 1'b1, 5'(16 + g), g);
  endtask
`endif

  initial begin
    // Reset held with all inputs valid
    a_in_valid = 4'hF;
    for (int k = 0; k < 4; k++) set_a(k, 5'(k + 1));
    a_sel = 2'd2;
    tick(); tick(); tick();
    check_out("reset", 1'b0, 5'h00, 2'd0);

    rst_n = 1'b1;
    set_a(2, 5'h15);
    settle();
    check("post_reset.in_ready", 32'(a_in_ready), 32'h4);
    tick();
    check_out("first_load", 1'b1, 5'h15, 2'd2);

    // SELECT backpressure on channel 1
    a_sel = 2'd1; a_in_valid = 4'b0010; set_a(1, 5'd1);
    tick();
    check_out("bp_w1", 1'b1, 5'd1, 2'd1);
    a_out_ready = 1'b0; set_a(1, 5'd2);
    settle();
    check("bp_stall.in_ready", 32'(a_in_ready), 32'h0);
    tick();
    check_out("bp_hold1", 1'b1, 5'd1, 2'd1);
    check("bp_hold1.in_ready", 32'(a_in_ready), 32'h0);
    a_sel = 2'd3;
    tick();
    check_out("bp_hold2", 1'b1, 5'd1, 2'd1);
    a_sel = 2'd1; a_out_ready = 1'b1;
    settle();
    check("bp_release.in_ready", 32'(a_in_ready), 32'h2);
    tick();
    check_out("bp_w2", 1'b1, 5'd2, 2'd1);
    set_a(1, 5'd3);
    tick();
    check_out("bp_w3", 1'b1, 5'd3, 2'd1);
    a_in_valid = 4'b0000;
    settle();
    check("sel_ready_no_valid", 32'(a_in_ready), 32'h2);
    tick();
    check_out("bp_drain", 1'b0, 5'd3, 2'd1);

    // Out-of-range select on the 3-channel instance
    b_sel = 2'd2; b_in_valid = 3'b111; b_in_data[10 +: 5] = 5'h0A;
    tick();
    check("oor_load.valid", 32'(b_out_valid), 32'h1);
    check("oor_load.data",  32'(b_out_data),  32'h0A);
    b_sel = 2'd3;
    settle();
    check("oor.in_ready", 32'(b_in_ready), 32'h0);
    tick();
    check("oor_drain.valid", 32'(b_out_valid), 32'h0);
    check("oor_drain.data",  32'(b_out_data),  32'h0A);
    check("oor_drain.grant", 32'(b_grant_id),  32'h2);
    check("oor_idle.in_ready", 32'(b_in_ready), 32'h0);

    // Mid-operation reset with a stalled word
    a_sel = 2'd0; a_in_valid = 4'b0001; set_a(0, 5'h07);
    tick();
    check_out("mid_load", 1'b1, 5'h07, 2'd0);
    a_out_ready = 1'b0; a_in_valid = 4'b0000; rst_n = 1'b0;
    tick();
    check_out("mid_reset", 1'b0, 5'h00, 2'd0);
    rst_n = 1'b1; a_out_ready = 1'b1;

`ifdef MUXN_STREAM_RR_EN
    a_mode = 1'b1; a_in_valid = 4'hF;
    for (int k = 0; k < 4; k++) set_a(k, 5'(16 + k));
    rr_step("rr0", 2'd0);
    rr_step("rr1", 2'd1);
    rr_step("rr2", 2'd2);
    rr_step("rr3", 2'd3);
    rr_step("rr4", 2'd0);
    rr_step("rr5", 2'd1);
    rr_step("rr6", 2'd2);
    rr_step("rr7", 2'd3);
    a_in_valid = 4'b1010;
    rr_step("skip0", 2'd1);
    rr_step("skip1", 2'd3);
    rr_step("skip2", 2'd1);
    a_in_valid = 4'b0000;
    settle();
    check("rr_idle.in_ready", 32'(a_in_ready), 32'h0);
    tick();
    check_out("rr_drain", 1'b0, 5'd17, 2'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
